// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions: operand-forward select encodings, also used by the
// EX operand mux, plus the hazard-cause bundle used by the hazard unit.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_LL    = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic load_use;
    logic scoreboard;
    logic waw;
  } hazard_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Forward-source select for one EX read port. Priority: long-latency writeback,
// then EX/MEM, then MEM/WB. Register 0 never forwards.
module fwd_port_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_ex_rs,
  input  logic          i_ll_done,
  input  logic [AW-1:0] i_ll_done_rd,
  input  logic          i_ex_mem_reg_write,
  input  logic [AW-1:0] i_ex_mem_rd,
  input  logic          i_mem_wb_reg_write,
  input  logic [AW-1:0] i_mem_wb_rd,
  output fwd_sel_e      o_sel
);

  logic w_nz;
  assign w_nz = (i_ex_rs != '0);

  always_comb begin
    o_sel = FWD_RF;
    if (w_nz) begin
      if (i_ll_done && (i_ll_done_rd == i_ex_rs))
        o_sel = FWD_LL;
      else if (i_ex_mem_reg_write && (i_ex_mem_rd == i_ex_rs))
        o_sel = FWD_EXMEM;
      else if (i_mem_wb_reg_write && (i_mem_wb_rd == i_ex_rs))
        o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: per-port forward selects, load-use / scoreboard / WAW
// stall, long-latency busy scoreboard, stall counter and sticky protocol error.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_RP = 2,
  parameter int AW     = 5,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RP*AW-1:0] id_rs,
  input  logic [NUM_RP-1:0]    id_rs_valid,
  input  logic [NUM_RP*AW-1:0] ex_rs,
  input  logic [AW-1:0]        id_ex_rd,
  input  logic                 id_ex_reg_write,
  input  logic                 id_ex_mem_read,
  input  logic [AW-1:0]        ex_mem_rd,
  input  logic                 ex_mem_reg_write,
  input  logic [AW-1:0]        mem_wb_rd,
  input  logic                 mem_wb_reg_write,
  input  logic                 ll_issue,
  input  logic [AW-1:0]        ll_issue_rd,
  input  logic                 ll_done,
  input  logic [AW-1:0]        ll_done_rd,
  output logic [NUM_RP*2-1:0]  fwd_sel,
  output logic                 stall,
  output logic [2**AW-1:0]     busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 sb_err
);

  localparam int NREGS = 2**AW;

  logic [NREGS-1:0] r_busy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_sb_err;

  logic [NREGS-1:0] w_busy_nxt;
  logic             w_err;
  hazard_t          w_haz;
  logic             w_stall;
  fwd_sel_e         w_sel [NUM_RP];

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    fwd_port_sel #(.AW(AW)) u_sel (
      .i_ex_rs            (ex_rs[p*AW +: AW]),
      .i_ll_done          (ll_done),
      .i_ll_done_rd       (ll_done_rd),
      .i_ex_mem_reg_write (ex_mem_reg_write),
      .i_ex_mem_rd        (ex_mem_rd),
      .i_mem_wb_reg_write (mem_wb_reg_write),
      .i_mem_wb_rd        (mem_wb_rd),
      .o_sel              (w_sel[p])
    );
    assign fwd_sel[2*p +: 2] = w_sel[p];
  end

  // A source whose long-latency result lands this cycle is forwarded, not stalled.
  always_comb begin
    logic [AW-1:0] w_rs;
    w_haz = '0;
    w_rs  = '0;
    for (int p = 0; p < NUM_RP; p++) begin
      w_rs = id_rs[p*AW +: AW];
      if (id_rs_valid[p] && (w_rs != '0)) begin
        if (id_ex_mem_read && id_ex_reg_write && (id_ex_rd == w_rs))
          w_haz.load_use = 1'b1;
        if (r_busy[w_rs] && !(ll_done && (ll_done_rd == w_rs)))
          w_haz.scoreboard = 1'b1;
      end
    end
    if (ll_issue && (ll_issue_rd != '0) && r_busy[ll_issue_rd] &&
        !(ll_done && (ll_done_rd == ll_issue_rd)))
      w_haz.waw = 1'b1;
  end

  assign w_stall = |w_haz;

  // Clear on writeback first so a same-cycle accepted issue to that rd wins.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err      = 1'b0;
    if (ll_done && (ll_done_rd != '0)) begin
      if (r_busy[ll_done_rd]) w_busy_nxt[ll_done_rd] = 1'b0;
      else                    w_err = 1'b1;
    end
    if (ll_issue && !w_stall && (ll_issue_rd != '0))
      w_busy_nxt[ll_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err) r_sb_err <= 1'b1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign busy      = r_busy;
  assign stall_cnt = r_stall_cnt;
  assign sb_err    = r_sb_err;

endmodule
